// File: rtl/metric_memory_unit_pkg.sv
// Shared widths, FSM encodings and the seed pattern for the Viterbi path-metric store.
// Pure declarations; no latency or flow control of its own.
package metric_memory_unit_pkg;

    localparam int WD_METR       = 8;
    localparam int N_STATE       = 256;
    localparam logic [WD_METR-1:0] INIT_METRIC = 8'h3F;

    localparam int METR_PER_WORD = 8;
    localparam int WD_WORD       = WD_METR * METR_PER_WORD;
    localparam int WD_HALF       = WD_WORD / 2;
    localparam int N_WORD        = N_STATE / METR_PER_WORD;
    localparam int WD_RADDR      = 5;
    localparam int WD_WADDR      = 6;

    localparam logic [WD_RADDR-1:0] SWEEP_LAST = WD_RADDR'(N_WORD - 1);

    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_SWEEP = 2'd1,
        MM_RUN   = 2'd2
    } mm_state_e;

    typedef struct packed {
        logic                lo_vld;
        logic                hi_vld;
        logic [WD_RADDR-1:0] adr;
        logic [WD_WORD-1:0]  dat;
    } mm_wr_t;

    // Word 0 carries state 0 in lane 0, which is the only state seeded to zero.
    function automatic logic [WD_WORD-1:0] sweep_word(input logic [WD_RADDR-1:0] idx);
        logic [WD_WORD-1:0] w;
        w = {METR_PER_WORD{INIT_METRIC}};
        if (idx == '0) begin
            w[WD_METR-1:0] = '0;
        end
        return w;
    endfunction

endpackage

// File: rtl/metric_memory_unit_mm_bank.sv
// One 32x64 metric bank: half-word write enables, 1-cycle registered read that holds when idle.
// No backpressure; a write and a read may land in the same cycle and the read sees old data.
module mm_bank
    import metric_memory_unit_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  mm_wr_t              wr,
    input  logic                rd_vld,
    input  logic [WD_RADDR-1:0] rd_adr,
    output logic [WD_WORD-1:0]  rd_dat
);

    logic [WD_WORD-1:0] mem [N_WORD];

    always_ff @(posedge Clock) begin
        if (wr.lo_vld) begin
            mem[wr.adr][WD_HALF-1:0] <= wr.dat[WD_HALF-1:0];
        end
        if (wr.hi_vld) begin
            mem[wr.adr][WD_WORD-1:WD_HALF] <= wr.dat[WD_WORD-1:WD_HALF];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_dat <= '0;
        end else if (rd_vld) begin
            rd_dat <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/metric_memory_unit.sv
// Ping-pong path-metric store with init sweep FSM; reads return one cycle after the strobe.
// No backpressure: Busy/Ready are status only, and accesses during the sweep are dropped or read as zero.
module metric_memory_unit
    import metric_memory_unit_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Init,
    input  logic                MMBlockSelect,
    input  logic                MMReadEnable,
    input  logic [WD_RADDR-1:0] MMReadAddress,
    input  logic                MMWriteEnable,
    input  logic [WD_WADDR-1:0] MMWriteAddress,
    input  logic [WD_HALF-1:0]  MMMetric,
    output logic [WD_WORD-1:0]  MMPathMetric,
    output logic                Ready,
    output logic                Busy
);

    mm_state_e           state;
    logic [WD_RADDR-1:0] sweep_cnt;
    logic                sweep_bank;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= MM_IDLE;
            sweep_cnt  <= '0;
            sweep_bank <= 1'b0;
            Busy       <= 1'b0;
            Ready      <= 1'b0;
        end else if (Init) begin
            state      <= MM_SWEEP;
            sweep_cnt  <= '0;
            sweep_bank <= ~MMBlockSelect;
            Busy       <= 1'b1;
            Ready      <= 1'b0;
        end else begin
            case (state)
                MM_SWEEP: begin
                    if (sweep_cnt == SWEEP_LAST) begin
                        state <= MM_RUN;
                        Busy  <= 1'b0;
                        Ready <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Init takes priority over both the sweep write and any external write in its cycle.
    logic   sweep_act;
    logic   ext_act;
    logic   rd_act;
    mm_wr_t sweep_wr;
    mm_wr_t ext_wr;
    mm_wr_t bank_wr [2];

    assign sweep_act = (state == MM_SWEEP) && !Init;
    assign ext_act   = MMWriteEnable && !Init && (state != MM_SWEEP);
    assign rd_act    = MMReadEnable && (state != MM_SWEEP);

    always_comb begin
        sweep_wr.lo_vld = 1'b1;
        sweep_wr.hi_vld = 1'b1;
        sweep_wr.adr    = sweep_cnt;
        sweep_wr.dat    = sweep_word(sweep_cnt);

        ext_wr.lo_vld   = !MMWriteAddress[0];
        ext_wr.hi_vld   = MMWriteAddress[0];
        ext_wr.adr      = MMWriteAddress[WD_WADDR-1:1];
        ext_wr.dat      = {MMMetric, MMMetric};

        bank_wr[0] = '0;
        bank_wr[1] = '0;
        if (sweep_act) begin
            bank_wr[sweep_bank] = sweep_wr;
        end else if (ext_act) begin
            bank_wr[MMBlockSelect] = ext_wr;
        end
    end

    logic [WD_WORD-1:0] bank_rd [2];

    mm_bank u_bank0 (
        .Clock  (Clock),
        .Reset  (Reset),
        .wr     (bank_wr[0]),
        .rd_vld (rd_act && MMBlockSelect),
        .rd_adr (MMReadAddress),
        .rd_dat (bank_rd[0])
    );

    mm_bank u_bank1 (
        .Clock  (Clock),
        .Reset  (Reset),
        .wr     (bank_wr[1]),
        .rd_vld (rd_act && !MMBlockSelect),
        .rd_adr (MMReadAddress),
        .rd_dat (bank_rd[1])
    );

    // Output stage: which bank answered the last strobe, and whether it arrived mid-sweep.
    logic rd_sel_q;
    logic rd_zero_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_sel_q  <= 1'b0;
            rd_zero_q <= 1'b1;
        end else if (MMReadEnable) begin
            rd_sel_q  <= ~MMBlockSelect;
            rd_zero_q <= (state == MM_SWEEP);
        end
    end

    assign MMPathMetric = rd_zero_q ? '0 : bank_rd[rd_sel_q];

endmodule
